// File: rtl/crt_demod.sv
// crt_demod: synchronous square-wave demodulator. It accumulates +/- ADC samples over 2^ACC_LOG2 modulation periods.
// Latency: the result appears one clock after the rise that closes a window. Windows are gap-free.
// No backpressure: a one-cycle Demod_Valid pulse, and Demod_Out holds. Optional macro CRT_DEMOD_SAT_EN saturates the output instead of wrapping.
module crt_demod #(
    parameter int ADC_W    = 14,
    parameter int ACC_LOG2 = 6,
    parameter int SKIP     = 1,
    parameter int OUT_W    = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                    Refin_Clk,
    input  logic                    SYS_RST,
    input  logic                    Mod_Phase,
    input  logic signed [ADC_W-1:0] Adc_Data,
    input  logic                    Adc_Valid,
    output logic signed [OUT_W-1:0] Demod_Out,
    output logic                    Demod_Valid,
    output logic                    Phase_Err
);

    // Accumulator headroom covers 256 full-scale samples per period over the whole window
    localparam int ACC_W = ADC_W + ACC_LOG2 + 8;
    localparam int PER_W = ACC_LOG2 + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int SK_W  = $clog2(SKIP + 2);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'((1 << ACC_LOG2) - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [SK_W-1:0]  SKIP_V   = SK_W'(SKIP);

`ifdef CRT_DEMOD_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - 1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic                    phase_q;
    logic                    phase_arm;
    logic                    rise;
    logic                    phase_edge;
    logic [SK_W-1:0]         skip_cnt;
    logic [SK_W-1:0]         skip_eff;
    logic                    discard;
    logic [PER_W-1:0]        per_cnt;
    logic [WD_W-1:0]         wd_cnt;
    logic                    wd_expire;
    logic signed [ACC_W-1:0] samp_ext;
    logic signed [ACC_W-1:0] contrib;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_shift;
    logic signed [OUT_W-1:0] out_red;

    // FSM output decodes
    logic win_start;
    logic win_close;
    logic acc_add;
    logic err_set;

    // Delayed copy of the modulation input. phase_arm blocks the first cycle after reset,
    // so a Mod_Phase that is already high is not taken as a rise.
    always_ff @(posedge Refin_Clk) begin
        if (SYS_RST) begin
            phase_q   <= 1'b0;
            phase_arm <= 1'b0;
        end else begin
            phase_q   <= Mod_Phase;
            phase_arm <= 1'b1;
        end
    end

    assign rise       = phase_arm & Mod_Phase & ~phase_q;
    assign phase_edge = phase_arm & (Mod_Phase ^ phase_q);

    // Settling counter: restarts at every edge and saturates once SKIP samples have gone by
    always_ff @(posedge Refin_Clk) begin
        if (SYS_RST) begin
            skip_cnt <= '0;
        end else if (phase_edge) begin
            skip_cnt <= SK_W'(1);
        end else if (skip_cnt < SKIP_V) begin
            skip_cnt <= skip_cnt + SK_W'(1);
        end
    end

    // The sample in the edge cycle counts as settling sample 0
    assign skip_eff = phase_edge ? '0 : skip_cnt;
    assign discard  = (skip_eff < SKIP_V);

    // Signed contribution of this cycle's sample: add in the high half, subtract in the low half
    always_comb begin
        samp_ext = {{(ACC_W - ADC_W){Adc_Data[ADC_W-1]}}, Adc_Data};
        contrib  = '0;
        if (Adc_Valid && !discard) begin
            contrib = Mod_Phase ? samp_ext : -samp_ext;
        end
    end

    // Watchdog: clocks elapsed since the most recent rise while accumulating
    always_ff @(posedge Refin_Clk) begin
        if (SYS_RST) begin
            wd_cnt <= '0;
        end else if (state != ACC || rise) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LAST) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_expire = (state == ACC) && !rise && (wd_cnt == WD_LAST);

    // Period counter: counts the rises seen inside the current window
    always_ff @(posedge Refin_Clk) begin
        if (SYS_RST) begin
            per_cnt <= '0;
        end else if (state != ACC) begin
            per_cnt <= '0;
        end else if (rise) begin
            per_cnt <= win_close ? '0 : per_cnt + PER_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge Refin_Clk) begin
        if (SYS_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rise)      state_nx = ACC;
            ACC:     if (wd_expire) state_nx = ERR;
            ERR:     if (rise)      state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // FSM output decode: window start/close, accumulate enable, error set
    always_comb begin
        win_start = 1'b0;
        win_close = 1'b0;
        acc_add   = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: win_start = rise;
            ACC: begin
                win_close = rise && (per_cnt == PER_LAST);
                acc_add   = !win_close;
                err_set   = wd_expire;
            end
            default: ;
        endcase
    end

    // Accumulator: at a window boundary it reloads with the boundary sample, otherwise it integrates.
    // It is held at zero outside a window.
    always_ff @(posedge Refin_Clk) begin
        if (SYS_RST) begin
            acc <= '0;
        end else if (win_start || win_close) begin
            acc <= contrib;
        end else if (acc_add) begin
            acc <= acc + contrib;
        end else begin
            acc <= '0;
        end
    end

    // Average over the window, then narrow to the output width
    always_comb begin
        acc_shift = acc >>> ACC_LOG2;
`ifdef CRT_DEMOD_SAT_EN
        if (acc_shift > OUT_MAX) begin
            out_red = OUT_MAX[OUT_W-1:0];
        end else if (acc_shift < OUT_MIN) begin
            out_red = OUT_MIN[OUT_W-1:0];
        end else begin
            out_red = acc_shift[OUT_W-1:0];
        end
`else
        out_red = acc_shift[OUT_W-1:0];
`endif
    end

    // Output registers: the result holds between pulses, and the error flag is sticky until reset
    always_ff @(posedge Refin_Clk) begin
        if (SYS_RST) begin
            Demod_Out   <= '0;
            Demod_Valid <= 1'b0;
            Phase_Err   <= 1'b0;
        end else begin
            Demod_Valid <= win_close;
            if (win_close) begin
                Demod_Out <= out_red;
            end
            if (err_set) begin
                Phase_Err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crt_demod.sv
// Scoreboard bench for crt_demod. Three instances share one stimulus: base, SKIP=1, and OUT_W=12.
// Expected window results are queued when a window's first sample is driven, and a monitor checks each pulse.
// With CRT_DEMOD_SAT_EN defined, the full-scale expectations switch to saturated values.
module tb_crt_demod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                mp;
    logic                av;
    logic signed [13:0]  ad;
    logic signed [15:0]  out0;
    logic signed [15:0]  out1;
    logic signed [11:0]  out2;
    logic                v0, v1, v2;
    logic                e0, e1, e2;

    crt_demod #(.ADC_W(14), .ACC_LOG2(2), .SKIP(0), .OUT_W(16), .TIMEOUT(32)) dut0 (
        .Refin_Clk(clk), .SYS_RST(rst), .Mod_Phase(mp), .Adc_Data(ad), .Adc_Valid(av),
        .Demod_Out(out0), .Demod_Valid(v0), .Phase_Err(e0));

    crt_demod #(.ADC_W(14), .ACC_LOG2(2), .SKIP(1), .OUT_W(16), .TIMEOUT(32)) dut1 (
        .Refin_Clk(clk), .SYS_RST(rst), .Mod_Phase(mp), .Adc_Data(ad), .Adc_Valid(av),
        .Demod_Out(out1), .Demod_Valid(v1), .Phase_Err(e1));

    crt_demod #(.ADC_W(14), .ACC_LOG2(2), .SKIP(0), .OUT_W(12), .TIMEOUT(32)) dut2 (
        .Refin_Clk(clk), .SYS_RST(rst), .Mod_Phase(mp), .Adc_Data(ad), .Adc_Valid(av),
        .Demod_Out(out2), .Demod_Valid(v2), .Phase_Err(e2));

    typedef struct {
        int r0;
        int r1;
        int r2;
        int at;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   ncyc     = 0;

    // Pattern table. The index is the pattern:
    //   0 = const +100
    //   1 = +/-100 in phase
    //   2 = inverted
    //   3 = +/-8191 in phase
    //   4 = pattern 1 with the last low sample invalid
    int exp0[5];
    int exp1[5];
    int exp2[5];

    always @(negedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, ncyc);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard in time and value
    always @(negedge clk) begin
        if (v0 || v1 || v2) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("pulse_time", ncyc, mon_e.at);
                chk("valid_all", int'({v0, v1, v2}), 7);
                chk("out_base", int'(out0), mon_e.r0);
                chk("out_skip1", int'(out1), mon_e.r1);
                chk("out_w12", int'(out2), mon_e.r2);
            end
        end
    end

    function automatic logic signed [13:0] pdat(input int pat, input logic m);
        case (pat)
            0:       return 14'sd100;
            1, 4:    return m ? 14'sd100 : -14'sd100;
            2:       return m ? -14'sd100 : 14'sd100;
            default: return m ? 14'sd8191 : -14'sd8191;
        endcase
    endfunction

    task automatic drive(input logic m, input logic signed [13:0] d, input logic v);
        @(negedge clk);
        mp = m;
        ad = d;
        av = v;
    endtask

    task automatic period(input int pat);
        for (int i = 0; i < 6; i++) begin
            logic m;
            m = (i < 3);
            drive(m, pdat(pat, m), !(pat == 4 && i == 5));
        end
    endtask

    // One full window of four periods. The result pulses one clock after the next window's first rise.
    task automatic window(input int pat);
        exp_t t;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 6; i++) begin
                logic m;
                m = (i < 3);
                drive(m, pdat(pat, m), !(pat == 4 && i == 5));
                if (p == 0 && i == 0) begin
                    t.r0 = exp0[pat];
                    t.r1 = exp1[pat];
                    t.r2 = exp2[pat];
                    t.at = ncyc + 25;
                    sbq.push_back(t);
                end
            end
        end
    endtask

    task automatic hold(input logic m, input int n);
        for (int i = 0; i < n; i++) drive(m, -14'sd100, 1'b1);
    endtask

    initial begin
        exp0 = '{0, 600, -600, 0, 500};
        exp1 = '{0, 400, -400, 32764, 300};
        exp2 = '{0, 600, -600, 0, 500};
`ifdef CRT_DEMOD_SAT_EN
        exp0[3] = 32767;
        exp2[3] = 2047;
`else
        exp0[3] = -16390;
        exp2[3] = -6;
`endif
        rst = 1'b1;
        mp  = 1'b0;
        av  = 1'b1;
        ad  = '0;
        hold(1'b0, 3);
        chk("rst_out_base", int'(out0), 0);
        chk("rst_out_skip1", int'(out1), 0);
        chk("rst_out_w12", int'(out2), 0);
        chk("rst_valid", int'({v0, v1, v2}), 0);
        chk("rst_err", int'({e0, e1, e2}), 0);
        rst = 1'b0;
        hold(1'b0, 4);

        // Steady windows across all patterns
        window(0);
        window(0);
        window(1);
        window(2);
        window(3);
        window(4);
        window(1);

        // Lose modulation mid-window: error with no pulse, then recover
        period(1);
        period(1);
        hold(1'b0, 40);
        chk("err_set", int'({e0, e1, e2}), 7);
        period(1);
        window(1);
        window(2);
        period(1);
        hold(1'b0, 10);
        chk("err_sticky", int'({e0, e1, e2}), 7);

        // Reset mid-window with Mod_Phase high through and after reset
        period(1);
        rst = 1'b1;
        hold(1'b1, 2);
        rst = 1'b0;
        hold(1'b1, 1);
        chk("rst2_out_base", int'(out0), 0);
        chk("rst2_out_w12", int'(out2), 0);
        chk("rst2_valid", int'({v0, v1, v2}), 0);
        chk("rst2_err", int'({e0, e1, e2}), 0);
        hold(1'b1, 2);
        hold(1'b0, 3);
        window(1);
        period(0);
        hold(1'b0, 10);

        chk("queue_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crt_demod.md
CRT_DEMOD -- requirements
Module: crt_demod

Interface
REQ-001 Parameter ADC_W, default 14: signed ADC sample width.
REQ-002 Parameter ACC_LOG2, default 6: window length is 2^ACC_LOG2 modulation periods.
REQ-003 Parameter SKIP, default 1: settling samples discarded after each Mod_Phase edge.
REQ-004 Parameter OUT_W, default 16: signed output width.
REQ-005 Parameter TIMEOUT, default 1024: maximum number of clocks between Mod_Phase rising edges.
REQ-006 Refin_Clk  input  1  single clock; all logic runs on its rising edge.
REQ-007 SYS_RST  input  1  synchronous, active-high reset.
REQ-008 Mod_Phase  input  1  modulation square wave (Eigen_Freq_Crt) from the eigen-frequency generator, synchronous to Refin_Clk.
REQ-009 Adc_Data  input  ADC_W  signed two's-complement detector sample.
REQ-010 Adc_Valid  input  1  Adc_Data is valid this cycle.
REQ-011 Demod_Out  output  OUT_W  signed demodulated result.
REQ-012 Demod_Valid  output  1  one-cycle pulse when Demod_Out updates.
REQ-013 Phase_Err  output  1  sticky flag: modulation lost.

Function
REQ-014 Phase_q SHALL be Mod_Phase delayed one clock; rise = Mod_Phase & !Phase_q; edge = Mod_Phase ^ Phase_q.
REQ-015 FSM states: IDLE, ACC, ERR; after reset the FSM is in IDLE.
REQ-016 IDLE -> ACC on the first rise; the sample in the rise cycle is the first sample of the window.
REQ-017 In ACC, a sample with Adc_Valid=1 SHALL be added to the accumulator when Mod_Phase=1 and subtracted when Mod_Phase=0, unless it is discarded under REQ-018.
REQ-018 A skip counter SHALL clear on every edge; a sample SHALL be discarded while the counter is below SKIP (counting the edge-cycle sample as count 0). SKIP=0 disables discarding.
REQ-019 The accumulator SHALL be signed, ADC_W+ACC_LOG2+8 bits wide, with no internal overflow for up to 256 samples per period.
REQ-020 A period counter SHALL increment on each rise in ACC; the rise that completes 2^ACC_LOG2 periods closes the window.
REQ-021 At close (rise cycle t): at t+1, Demod_Out = accumulator (excluding the cycle-t sample) arithmetically shifted right by ACC_LOG2 and then width-reduced per REQ-030, and Demod_Valid=1 for exactly one cycle.
REQ-022 At close, the accumulator SHALL reload with the cycle-t sample contribution (or 0 if it is discarded or invalid), and the period counter SHALL reset; windows are gap-free.
REQ-023 Adc_Valid=0 SHALL leave the accumulator unchanged; period counting continues.
REQ-024 A watchdog SHALL count clocks since the last rise in ACC; on reaching TIMEOUT, the FSM SHALL go to ERR, Phase_Err=1, and the partial window is discarded without a Demod_Valid pulse.
REQ-025 ERR -> IDLE on the next rise; Phase_Err stays 1 until SYS_RST.
REQ-026 Demod_Out SHALL hold its value between pulses.

Reset
REQ-027 While SYS_RST=1 at a clock edge: FSM=IDLE, accumulator, period, skip and watchdog counters=0, Phase_q=0, Demod_Out=0, Demod_Valid=0, Phase_Err=0.
REQ-028 Reset mid-window SHALL discard the partial sum; no Demod_Valid pulse occurs for the aborted window.
REQ-029 After reset deasserts, the first rise SHALL be the first window start; a Mod_Phase that is already high SHALL NOT count as a rise.

Configuration
REQ-030 Macro CRT_DEMOD_SAT_EN: when defined, the shifted result SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; when undefined, Demod_Out SHALL take the low OUT_W bits (wrap).

Verification (ADC_W=14, ACC_LOG2=2, SKIP=0, OUT_W=16; Mod_Phase 3 clocks high / 3 low; Adc_Valid=1)
REQ-031 Adc_Data constant +100 -> Demod_Out=0 with one Demod_Valid pulse every 24 clocks.
REQ-032 Adc_Data=+100 while Mod_Phase=1 and -100 while Mod_Phase=0 -> Demod_Out=600; inverted pattern -> -600.
REQ-033 SKIP=1 with the REQ-032 pattern -> Demod_Out=400.
REQ-034 Adc_Data=+8191 in-phase, OUT_W=12 -> with CRT_DEMOD_SAT_EN, Demod_Out=2047; without it, Demod_Out = low 12 bits of 49146.
REQ-035 Mod_Phase held low for TIMEOUT clocks mid-window -> Phase_Err=1 with no pulse; the next window after a rise -> correct value, Phase_Err still 1.
REQ-036 SYS_RST pulsed mid-window -> all outputs 0 and no pulse for the aborted window; the first pulse comes 4 periods after the first post-reset rise.
